// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter: mode constants,
// the per-edge action encoding and the max-count helper.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_INC,
        ACT_DEC
    } cnt_act_t;

    function automatic int unsigned max_count(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/updown_counter_param_tff_cell.sv
// One bit of the counter: a toggle flop with synchronous load and a
// registered complement output, cleared asynchronously.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic ld,
    input  logic ld_d,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= 1'b0;
            q_bar <= 1'b1;
        end else if (ld) begin
            q     <= ld_d;
            q_bar <= ~ld_d;
        end else if (t) begin
            q     <= ~q;
            q_bar <= q;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down modulo counter with load, enable, wrap/saturate mode,
// combinational terminal count and a registered one-cycle wrap pulse.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(max_count(MODULUS));
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);
    localparam bit             SAT     = (SATURATE == CNT_SAT);

    cnt_act_t         act;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   next_ext;
    logic [WIDTH-1:0] next;
    logic [WIDTH-1:0] t;
    logic             at_max;
    logic             at_min;
    logic             wrap_next;
    logic             carry_unused;

    assign q_ext  = {1'b0, q};
    assign d_ext  = {1'b0, d};
    assign at_max = (q_ext == MAX_EXT);
    assign at_min = (q_ext == '0);

    always_comb begin
        act = ACT_HOLD;
        if (load)
            act = ACT_LOAD;
        else if (en)
            act = up ? ACT_INC : ACT_DEC;
    end

    // Limits compare against MAX_EXT explicitly so MODULUS == 2**WIDTH
    // never relies on natural overflow of the WIDTH-bit register.
    always_comb begin
        next_ext  = q_ext;
        wrap_next = 1'b0;
        case (act)
            ACT_LOAD: next_ext = (d_ext > MAX_EXT) ? MAX_EXT : d_ext;
            ACT_INC: begin
                if (!at_max) begin
                    next_ext = q_ext + ONE_EXT;
                end else if (!SAT) begin
                    next_ext  = '0;
                    wrap_next = 1'b1;
                end
            end
            ACT_DEC: begin
                if (!at_min) begin
                    next_ext = q_ext - ONE_EXT;
                end else if (!SAT) begin
                    next_ext  = MAX_EXT;
                    wrap_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign next         = next_ext[WIDTH-1:0];
    assign carry_unused = next_ext[WIDTH];
    assign t            = q ^ next;

    assign tc = en & ~load & ((up & at_max) | (~up & at_min));

    // Counting is expressed as per-bit toggles; a load bypasses the toggle
    // path and writes the clamped value directly.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .t     (t[i]),
            .ld    (load),
            .ld_d  (next[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wrap <= 1'b0;
        else
            wrap <= wrap_next;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Synchronous, parametrised up/down modulo counter. It generalises the team's fixed 4-bit up counter to any width and modulus, and adds direction control, parallel load, count enable, a saturate-or-wrap mode, a terminal-count flag and a wrap pulse. All flops share one clock, so there is no ripple clocking between stages. It is used as the general event/cycle counter in the team's sequential designs.

Parameters:
WIDTH, 4, counter width in bits; must be at least 1.
MODULUS, 16, count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limits.

Ports:
clk  input  1  single clock, rising-edge active
rst  input  1  asynchronous, active-high reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  parallel load strobe
d  input  WIDTH  parallel load value
q  output  WIDTH  registered count
q_bar  output  WIDTH  registered complement of q
tc  output  1  terminal count (combinational)
wrap  output  1  registered one-cycle wrap pulse

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset: while rst=1, regardless of clk: q=0, q_bar=all ones, wrap=0. When rst falls, counting resumes at the first rising edge of clk with rst=0.
- Reset mid-operation: clears state immediately. Any load or count in flight is lost.
- Priority at each rising edge: rst > load > en. With load=0 and en=0, q holds.
- load=1: q <= d if d <= MODULUS-1, else q <= MODULUS-1 (clamped). Load ignores en and up. wrap <= 0.
- en=1, up=1:
  - q < MODULUS-1: q <= q+1.
  - q = MODULUS-1, SATURATE=0: q <= 0, wrap <= 1.
  - q = MODULUS-1, SATURATE=1: q holds, wrap <= 0.
- en=1, up=0:
  - q > 0: q <= q-1.
  - q = 0, SATURATE=0: q <= MODULUS-1, wrap <= 1.
  - q = 0, SATURATE=1: q holds, wrap <= 0.
- wrap: high for exactly one cycle, the cycle after a wrap event; 0 otherwise. In SATURATE=1 it is never asserted.
- tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)). Purely combinational, so it predicts the wrap/hold at the coming edge.
- q_bar is always ~q, updated on the same edge (no skew cycle).
- Latency: a load or count is visible on q one cycle after the edge that samples it.
- Direction change: takes effect on the same edge it is sampled. Toggling up every cycle with en=1 gives alternating +1/-1.
- Arithmetic: next-state computed at WIDTH+1 bits and truncated. Values at or above MODULUS are unreachable except via load, and load clamps.
- MODULUS = 2**WIDTH: wrap comparison still uses the explicit MODULUS-1, with no overflow dependency.

Decomposition:
- Shared package counter_pkg holds:
  - Mode constants CNT_WRAP=0, CNT_SAT=1.
  - A helper function for the max count, MODULUS-1.
- Sub-module tff_cell: a single toggle cell with clk, asynchronous active-high rst, toggle input t, sync load input ld, load data ld_d, output q, q_bar.
  - The top computes the next count, derives the toggle vector t = q ^ next, and instantiates WIDTH tff_cell.
  - wrap flop and tc logic live in the top.

Test Plan:
- Reset/async: assert rst between clock edges while q=9 -> q=0, q_bar=4'hF, wrap=0 immediately, before any edge.
- Up wrap (WIDTH=4, MODULUS=10, SATURATE=0): en=1, up=1, 12 edges from 0 -> q reads 1..9,0,1,2; tc=1 while q=9; wrap=1 only in the cycle q=0 after the wrap.
- Down wrap and saturate: SATURATE=0, q=0, up=0, en=1 -> q=9, wrap pulse. SATURATE=1, same stimulus -> q stays 0, wrap=0, tc=1.
- Load priority/clamp (MODULUS=10): load=1, en=1, d=7 -> q=7. Then d=13 -> q=9 (clamped). load=1 with tc conditions present -> tc=0.
- Full range (WIDTH=3, MODULUS=8): 16 up-counts from 0 -> two wraps, q_bar==~q every cycle.
- Direction toggle and enable: up alternating each cycle from q=5 -> 6,5,6,5. en=0 for 3 edges -> q holds, wrap=0.
